// File: rtl/stream_tb_pkg.sv
// Shared definitions for the stream test harness: FSM encoding, stall LFSR
// constants and the "no error recorded" marker.
package stream_tb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] NO_ERR    = 16'hFFFF;

   function automatic logic lfsr_fb(input logic [15:0] s);
      return ^(s & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/stream_test_harness_if.sv
// Harness <-> device-under-test stream bundle.
interface stream_test_harness_if #(
   parameter int DATAW = 32,
   parameter int NIN   = 2
) ();
   logic                  dut_ivalid;
   logic                  dut_stall;
   logic [NIN*DATAW-1:0]  dut_in_data;
   logic [DATAW-1:0]      dut_out_data;

   modport master (output dut_ivalid, output dut_stall, output dut_in_data,
                   input  dut_out_data);
   modport slave  (input  dut_ivalid, input  dut_stall, input  dut_in_data,
                   output dut_out_data);
endinterface

// File: rtl/stream_test_harness_stall_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; hit flags the low BITS bits all zero.
module stall_lfsr
   import stream_tb_pkg::*;
#(
   parameter int BITS = 3
) (
   input  logic clk,
   input  logic rst,
   output logic hit
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[14:0], lfsr_fb(lfsr_q)};

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign hit = (lfsr_q[BITS-1:0] == '0);

endmodule

// File: rtl/stream_test_harness.sv
// Streams preloaded vectors into a pipelined DUT and scores its output
// against a golden memory.
//
//  state | meaning
//  IDLE  | waiting for start after reset
//  RUN   | issuing input index i = 0..SIZE-1
//  DRAIN | inputs zeroed, collecting remaining results
//  DONE  | results final, waiting for start
module stream_test_harness
   import stream_tb_pkg::*;
#(
   parameter int DATAW      = 32,
   parameter int SIZE       = 32,
   parameter int NIN        = 2,
   parameter int LAT        = 5,
   parameter int STALL_EN   = 0,
   parameter int STALL_BITS = 3,
   localparam int AW        = $clog2(SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 load_we,
   input  logic [3:0]           load_sel,
   input  logic [AW-1:0]        load_addr,
   input  logic [DATAW-1:0]     load_data,
   stream_test_harness_if.master dut,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          err_count,
   output logic [15:0]          first_err_idx
);

   state_t          state_q, state_d;
   logic [AW-1:0]   i_q, i_d;
   logic [AW:0]     j_q, j_d;
   logic [LAT-1:0]  vsr_q, vsr_d;
   logic [15:0]     err_count_q, err_count_d;
   logic [15:0]     first_err_q, first_err_d;
   logic            pass_q, pass_d;
   logic            lfsr_hit, stall, ivalid, tail;

   logic [DATAW-1:0] in_mem   [NIN][SIZE];
   logic [DATAW-1:0] gold_mem [SIZE];

   assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   // Memories are not reset so their contents survive an aborted run.
   always_ff @(posedge clk) begin
      if (load_we && !busy) begin
         if (load_sel == 4'(NIN)) gold_mem[load_addr] <= load_data;
         for (int c = 0; c < NIN; c++)
            if (load_sel == 4'(c)) in_mem[c][load_addr] <= load_data;
      end
   end

   stall_lfsr #(.BITS(STALL_BITS)) u_stall_lfsr (
      .clk (clk),
      .rst (rst),
      .hit (lfsr_hit)
   );

   assign stall  = (STALL_EN != 0) && busy && lfsr_hit;
   assign ivalid = (state_q == ST_RUN) && !stall;
   assign tail   = vsr_q[LAT-1];

   assign dut.dut_stall  = stall;
   assign dut.dut_ivalid = ivalid;

   always_comb begin
      dut.dut_in_data = '0;
      if (state_q == ST_RUN)
         for (int c = 0; c < NIN; c++)
            dut.dut_in_data[c*DATAW +: DATAW] = in_mem[c][i_q];
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      err_count_d = err_count_q;
      first_err_d = first_err_q;
      pass_d      = pass_q;
      vsr_d       = stall ? vsr_q : ((vsr_q << 1) | LAT'(ivalid));

      if (tail && !stall) begin
         if (dut.dut_out_data != gold_mem[j_q[AW-1:0]]) begin
            if (err_count_q != NO_ERR) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0)  first_err_d = 16'(j_q);
         end
         j_d = j_q + (AW+1)'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               i_d         = '0;
               j_d         = '0;
               vsr_d       = '0;
               err_count_d = '0;
               first_err_d = NO_ERR;
               pass_d      = 1'b0;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               i_d = i_q + AW'(1);
               if (i_q == AW'(SIZE-1)) begin
                  i_d     = '0;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (j_q == (AW+1)'(SIZE)) begin
               state_d = ST_DONE;
               pass_d  = (err_count_q == 16'd0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         vsr_q       <= '0;
         err_count_q <= '0;
         first_err_q <= NO_ERR;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         vsr_q       <= vsr_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
         pass_q      <= pass_d;
      end
   end

   assign done          = (state_q == ST_DONE);
   assign pass          = pass_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_stream_test_harness.sv
// Directed bench: three harness instances (baseline, stalled, 4-channel LAT=1)
// each wrapped around a small behavioural adder DUT.
module tb_stream_test_harness;
   import stream_tb_pkg::*;

   logic clk, rst;
   logic start_a, start_b, start_c;
   logic load_we, b_load_en, load_we_b;
   logic [3:0]  load_sel;
   logic [4:0]  load_addr;
   logic [31:0] load_data;
   logic        load_we_c;
   logic [3:0]  sel_c;
   logic [0:0]  addr_c;
   logic [31:0] data_c;

   logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
   logic [15:0] err_a, first_a, err_b, first_b, err_c, first_c;

   int n_cmp = 0;
   int n_mis = 0;
   int viol_b = 0;
   int stall_seen_b = 0;

   stream_test_harness_if #(.DATAW(32), .NIN(2)) ifa ();
   stream_test_harness_if #(.DATAW(32), .NIN(2)) ifb ();
   stream_test_harness_if #(.DATAW(32), .NIN(4)) ifc ();

   assign load_we_b = load_we & b_load_en;

   stream_test_harness #(.DATAW(32), .SIZE(32), .NIN(2), .LAT(5), .STALL_EN(0), .STALL_BITS(3)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .load_we(load_we), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data), .dut(ifa), .busy(busy_a), .done(done_a),
      .pass(pass_a), .err_count(err_a), .first_err_idx(first_a));

   stream_test_harness #(.DATAW(32), .SIZE(32), .NIN(2), .LAT(5), .STALL_EN(1), .STALL_BITS(2)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .load_we(load_we_b), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data), .dut(ifb), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_count(err_b), .first_err_idx(first_b));

   stream_test_harness #(.DATAW(32), .SIZE(2), .NIN(4), .LAT(1), .STALL_EN(0), .STALL_BITS(3)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .load_we(load_we_c), .load_sel(sel_c),
      .load_addr(addr_c), .load_data(data_c), .dut(ifc), .busy(busy_c), .done(done_c),
      .pass(pass_c), .err_count(err_c), .first_err_idx(first_c));

   // Behavioural adder DUTs with a stall-frozen pipeline of LAT registers.
   logic [31:0] pa [5];
   logic [31:0] pb [5];
   logic [31:0] pc;

   always_ff @(posedge clk) begin
      if (!ifa.dut_stall) begin
         pa[0] <= ifa.dut_in_data[31:0] + ifa.dut_in_data[63:32];
         for (int k = 1; k < 5; k++) pa[k] <= pa[k-1];
      end
      if (!ifb.dut_stall) begin
         pb[0] <= ifb.dut_in_data[31:0] + ifb.dut_in_data[63:32];
         for (int k = 1; k < 5; k++) pb[k] <= pb[k-1];
      end
      if (!ifc.dut_stall)
         pc <= ifc.dut_in_data[31:0] + ifc.dut_in_data[63:32]
             + ifc.dut_in_data[95:64] + ifc.dut_in_data[127:96];
   end

   assign ifa.dut_out_data = pa[4];
   assign ifb.dut_out_data = pb[4];
   assign ifc.dut_out_data = pc;

   always @(negedge clk) begin
      if (ifb.dut_ivalid && ifb.dut_stall) viol_b++;
      if (ifb.dut_stall) stall_seen_b = 1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic load_ab(input logic [3:0] sel, input int addr, input logic [31:0] data);
      load_we = 1'b1; load_sel = sel; load_addr = 5'(addr); load_data = data;
      @(posedge clk); #1;
      load_we = 1'b0;
   endtask

   task automatic load_cc(input logic [3:0] sel, input int addr, input logic [31:0] data);
      load_we_c = 1'b1; sel_c = sel; addr_c = 1'(addr); data_c = data;
      @(posedge clk); #1;
      load_we_c = 1'b0;
   endtask

   function automatic logic dn(input int inst);
      case (inst)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic pulse(input int inst);
      case (inst)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
   endtask

   task automatic wait_done(input int inst, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!dn(inst) && n < 3000);
   endtask

   int n, seen_done;

   initial begin
      rst = 1'b1; start_a = 0; start_b = 0; start_c = 0;
      load_we = 0; load_sel = 0; load_addr = 0; load_data = 0; b_load_en = 1'b1;
      load_we_c = 0; sel_c = 0; addr_c = 0; data_c = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_busy",   32'(busy_a), 0);
      chk("rst_done",   32'(done_a), 0);
      chk("rst_pass",   32'(pass_a), 0);
      chk("rst_err",    32'(err_a), 0);
      chk("rst_first",  32'(first_a), 32'hFFFF);
      chk("rst_ivalid", 32'(ifa.dut_ivalid), 0);
      chk("rst_stall",  32'(ifb.dut_stall), 0);

      for (int i = 0; i < 32; i++) begin
         load_ab(4'd0, i, 32'(i));
         load_ab(4'd1, i, 32'(i));
         load_ab(4'd2, i, 32'(2*i));
      end
      load_ab(4'd3, 5, 32'd12345);   // out-of-range select: must be dropped
      b_load_en = 1'b0;

      // Baseline run
      pulse(0);
      chk("run_busy", 32'(busy_a), 1);
      wait_done(0, n);
      chk("base_latency", 32'(n), 38);
      chk("base_pass",    32'(pass_a), 1);
      chk("base_err",     32'(err_a), 0);
      chk("base_first",   32'(first_a), 32'hFFFF);
      chk("base_busy",    32'(busy_a), 0);

      // Two corrupted golden words
      load_ab(4'd2, 7, 32'd0);
      load_ab(4'd2, 20, 32'd0);
      pulse(0);
      wait_done(0, n);
      chk("err_pass",  32'(pass_a), 0);
      chk("err_count", 32'(err_a), 2);
      chk("err_first", 32'(first_a), 7);

      // Restart from DONE with a stray start while busy
      load_ab(4'd2, 7, 32'd14);
      load_ab(4'd2, 20, 32'd40);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) chk("restart_err_clr", 32'(err_a), 0);
         start_a = (n == 5);
      end while (!done_a && n < 3000);
      chk("busy_start_latency", 32'(n), 38);
      chk("restart_pass", 32'(pass_a), 1);
      chk("restart_err",  32'(err_a), 0);

      // Reset mid-run with a load attempted while busy
      pulse(0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 4) begin load_we = 1'b1; load_sel = 4'd2; load_addr = 5'd3; load_data = 32'd999; end
         if (n == 5) load_we = 1'b0;
         if (n == 10) begin
            chk("midrun_ivalid", 32'(ifa.dut_ivalid), 1);
            rst = 1'b1;
         end
         if (n == 11) rst = 1'b0;
      end while (n < 11);
      chk("abort_busy",  32'(busy_a), 0);
      chk("abort_done",  32'(done_a), 0);
      chk("abort_first", 32'(first_a), 32'hFFFF);
      seen_done = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (done_a) seen_done++;
      end
      chk("abort_no_done", 32'(seen_done), 0);
      pulse(0);
      wait_done(0, n);
      chk("post_abort_latency", 32'(n), 38);
      chk("post_abort_pass",    32'(pass_a), 1);
      chk("post_abort_err",     32'(err_a), 0);

      // Stall-injected instance
      pulse(1);
      wait_done(1, n);
      chk("stall_done",       32'(done_b), 1);
      chk("stall_pass",       32'(pass_b), 1);
      chk("stall_err",        32'(err_b), 0);
      chk("stall_ivalid_viol", 32'(viol_b), 0);
      chk("stall_seen",       32'(stall_seen_b), 1);

      // Four-channel, LAT=1, SIZE=2 instance: sums 64 and 68
      for (int c = 0; c < 4; c++) begin
         load_cc(4'(c), 0, 32'(10*c + 1));
         load_cc(4'(c), 1, 32'(10*c + 2));
      end
      load_cc(4'd4, 0, 32'd64);
      load_cc(4'd4, 1, 32'd68);
      pulse(2);
      wait_done(2, n);
      chk("c_latency", 32'(n), 4);
      chk("c_pass",    32'(pass_c), 1);
      chk("c_err",     32'(err_c), 0);
      chk("c_first",   32'(first_c), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/stream_test_harness.md
STREAM_TEST_HARNESS -- requirements
Module: stream_test_harness

Interface
REQ-001 Parameter DATAW, 32, stream word width in bits.
REQ-002 Parameter SIZE, 32, work-instances per run (>=2).
REQ-003 Parameter NIN, 2, input stream channel count (1..8).
REQ-004 Parameter LAT, 5, DUT input-to-output latency in non-stalled cycles (>=1).
REQ-005 Parameter STALL_EN, 0, enables pseudo-random stall injection when 1.
REQ-006 Parameter STALL_BITS, 3, stall probability is 2^-STALL_BITS per cycle.
REQ-007 clk  in  1  clock; rising-edge active.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  one-cycle pulse that begins a run.
REQ-010 load_we  in  1  memory write strobe.
REQ-011 load_sel  in  4  target memory: 0..NIN-1 input channel, NIN golden.
REQ-012 load_addr  in  clog2(SIZE)  memory word address.
REQ-013 load_data  in  DATAW  memory write data.
REQ-014 dut_ivalid  out  1  input word valid to DUT.
REQ-015 dut_stall  out  1  freezes DUT pipeline.
REQ-016 dut_in_data  out  NIN*DATAW  packed input words; channel c at bits [c*DATAW +: DATAW].
REQ-017 dut_out_data  in  DATAW  DUT result stream.
REQ-018 busy, done, pass  out  1 each  status flags.
REQ-019 err_count  out  16  saturating mismatch count.
REQ-020 first_err_idx  out  16  index of first mismatch; 16'hFFFF if none.

Function
REQ-021 FSM states: IDLE, RUN, DRAIN, DONE; start in IDLE or DONE enters RUN and clears counters and flags.
REQ-022 RUN: issue index i from 0 to SIZE-1; dut_in_data = in_mem[c][i]; dut_ivalid = !dut_stall; i advances only on a non-stalled cycle.
REQ-023 After index SIZE-1 issues, enter DRAIN: drive zeros with dut_ivalid=0 for LAT non-stalled cycles.
REQ-024 A LAT-deep valid shift register advances only when dut_stall=0; its tail marks dut_out_data as result j.
REQ-025 On a tail-valid, non-stalled edge, compare dut_out_data with gold_mem[j]; mismatch increments err_count (saturating at 16'hFFFF); the first mismatch loads first_err_idx=j; j then increments.
REQ-026 When j reaches SIZE, enter DONE; done=1, busy=0, pass=(err_count==0); hold until start or rst.
REQ-027 busy=1 in RUN and DRAIN only.
REQ-028 STALL_EN=1: dut_stall=1 in RUN/DRAIN when the low STALL_BITS bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) are all zero; the LFSR steps every cycle; dut_stall=0 otherwise and whenever STALL_EN=0.
REQ-029 load_we is ignored while busy; a load_sel value above NIN is ignored.
REQ-030 start is ignored while busy.
REQ-031 With STALL_EN=0, done rises exactly SIZE+LAT+1 cycles after the edge that samples start.

Reset
REQ-032 rst forces IDLE; dut_ivalid, dut_stall, busy, done, pass=0; err_count=0; first_err_idx=16'hFFFF; i, j and the valid shift register =0; LFSR=seed.
REQ-033 rst mid-run aborts the run with no done pulse; memory contents are preserved.

Structure
REQ-034 The state encoding, LFSR seed/taps and the NO_ERR constant 16'hFFFF reside in the shared stream_tb_pkg.
REQ-035 The LFSR is a sub-module named stall_lfsr; the memories are inferred arrays inside the harness.

Verification
REQ-036 NIN=2, in0[i]=in1[i]=i, gold[i]=2i, adder DUT with LAT=5, STALL_EN=0 -> pass=1, err_count=0, done 38 cycles after start.
REQ-037 Same setup with gold[7]=0 and gold[20]=0 -> pass=0, err_count=2, first_err_idx=7.
REQ-038 STALL_EN=1, STALL_BITS=2 -> pass=1; dut_ivalid never high while dut_stall=1; done still asserted.
REQ-039 rst asserted at issue index 10, then start -> a clean run passes; loads attempted during the run are ignored.
REQ-040 NIN=4, LAT=1, SIZE=2, gold[i]=sum of channels -> pass=1; done 4 cycles after start.
REQ-041 start pulsed while busy and again in DONE -> the first start is ignored; the second restarts with err_count=0.
